// File: rtl/iq_age_scheduler.sv
// Oldest-first issue selector for a small issue queue: keeps an age matrix over
// the slots, picks the lowest free slot for dispatch and grants the oldest ready slot.
module iq_age_scheduler #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [IDX_W-1:0] alloc_idx,
    input  logic             issue_fire,
    input  logic [DEPTH-1:0] flush_vec,
    input  logic [DEPTH-1:0] req_vec,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [DEPTH-1:0] grant_onehot,
    output logic [IDX_W-1:0] alloc_ptr,
    output logic [DEPTH-1:0] occupied,
    output logic             full,
    output logic             empty,
    output logic             err
);

    // age[i][j] = 1 means slot i is older than slot j
    logic [DEPTH-1:0] age [DEPTH];
    logic [DEPTH-1:0] eff_req;
    logic [DEPTH-1:0] grant_vec;
    logic [DEPTH-1:0] occ_pre;
    logic [DEPTH-1:0] occ_next;
    logic             alloc_err;
    logic             proto_err;

    always_comb begin
        eff_req   = req_vec & occupied;
        grant_vec = eff_req;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (j != i && eff_req[j] && !age[i][j]) begin
                    grant_vec[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (grant_vec[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign grant_valid  = |eff_req;
    assign grant_onehot = grant_vec;

    always_comb begin
        alloc_ptr = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (!occupied[i-1]) begin
                alloc_ptr = IDX_W'(i - 1);
            end
        end
    end

    assign full  = &occupied;
    assign empty = ~|occupied;

    // Issue clear, then flush clear; alloc is layered on top so it wins over flush.
    always_comb begin
        occ_pre = occupied;
        if (issue_fire && grant_valid) begin
            occ_pre[grant_idx] = 1'b0;
        end
        occ_pre  = occ_pre & ~flush_vec;
        occ_next = occ_pre;
        if (alloc_valid) begin
            occ_next[alloc_idx] = 1'b1;
        end
    end

    always_comb begin
        alloc_err = alloc_valid && (full || (alloc_idx != alloc_ptr) || occ_pre[alloc_idx]);
        proto_err = alloc_err || (issue_fire && !grant_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupied <= '0;
            err      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            occupied <= occ_next;
            if (proto_err) begin
                err <= 1'b1;
            end
            if (alloc_valid) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (IDX_W'(i) == alloc_idx) begin
                        age[i] <= '0;
                    end else if (occ_pre[i]) begin
                        age[i][alloc_idx] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_age_scheduler.sv
// Bench for iq_age_scheduler: directed scenarios plus random traffic checked
// against an age-ordered list model of the queue.
module tb_iq_age_scheduler;

    logic       clk;
    logic       rst;
    logic       alloc_valid;
    logic [1:0] alloc_idx;
    logic       issue_fire;
    logic [3:0] flush_vec;
    logic [3:0] req_vec;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] grant_onehot;
    logic [1:0] alloc_ptr;
    logic [3:0] occupied;
    logic       full;
    logic       empty;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: slot indices ordered oldest first; membership means occupied.
    int order[$];
    bit m_err;

    iq_age_scheduler #(.DEPTH(4), .IDX_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_idx    (alloc_idx),
        .issue_fire   (issue_fire),
        .flush_vec    (flush_vec),
        .req_vec      (req_vec),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .alloc_ptr    (alloc_ptr),
        .occupied     (occupied),
        .full         (full),
        .empty        (empty),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_has(input int s);
        foreach (order[n]) if (order[n] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_remove(input int s);
        for (int n = 0; n < order.size(); n++) begin
            if (order[n] == s) begin
                order.delete(n);
                return;
            end
        end
    endfunction

    function automatic int m_grant(input logic [3:0] rq);
        foreach (order[n]) if (rq[order[n]]) return order[n];
        return -1;
    endfunction

    function automatic int m_ptr();
        for (int s = 0; s < 4; s++) if (!m_has(s)) return s;
        return 0;
    endfunction

    function automatic int m_occ();
        int v = 0;
        foreach (order[n]) v |= (1 << order[n]);
        return v;
    endfunction

    // Entered just after a posedge; leaves just after the next posedge.
    task automatic cycle(input bit av, input int ai, input bit fi,
                         input logic [3:0] fl, input logic [3:0] rq, output int g_obs);
        int  g;
        bit  pre_full;
        int  pre_ptr;
        alloc_valid = av;
        alloc_idx   = 2'(ai);
        issue_fire  = fi;
        flush_vec   = fl;
        req_vec     = rq;
        @(negedge clk);
        g = m_grant(rq);
        check("grant_valid",  int'(grant_valid),  (g >= 0) ? 1 : 0);
        check("grant_idx",    int'(grant_idx),    (g >= 0) ? g : 0);
        check("grant_onehot", int'(grant_onehot), (g >= 0) ? (1 << g) : 0);
        check("alloc_ptr",    int'(alloc_ptr),    m_ptr());
        check("occupied",     int'(occupied),     m_occ());
        check("full",         int'(full),         (order.size() == 4) ? 1 : 0);
        check("empty",        int'(empty),        (order.size() == 0) ? 1 : 0);
        check("err",          int'(err),          int'(m_err));
        g_obs = int'(grant_idx);
        @(posedge clk);
        pre_full = (order.size() == 4);
        pre_ptr  = m_ptr();
        if (fi) begin
            if (g >= 0) m_remove(g);
            else m_err = 1'b1;
        end
        for (int s = 0; s < 4; s++) if (fl[s]) m_remove(s);
        if (av) begin
            if (pre_full || ai != pre_ptr || m_has(ai)) m_err = 1'b1;
            m_remove(ai);
            order.push_back(ai);
        end
        #1;
    endtask

    // Leaves alloc/req inputs as they are during the reset edge so a reset can land mid-fill.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        issue_fire  = 1'b0;
        flush_vec   = '0;
        req_vec     = '0;
        order.delete();
        m_err = 1'b0;
    endtask

    task automatic fill();
        int g;
        for (int k = 0; k < 4; k++) cycle(1'b1, k, 1'b0, 4'b0, 4'b0, g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit av, fi;
        int ai;
        logic [3:0] fl, rq;

        rst = 1'b1;
        alloc_valid = 1'b0; alloc_idx = '0; issue_fire = 1'b0;
        flush_vec = '0; req_vec = '0;
        do_reset();
        check("rst_gvalid", int'(grant_valid), 0);
        check("rst_gidx",   int'(grant_idx),   0);
        check("rst_onehot", int'(grant_onehot), 0);
        check("rst_ptr",    int'(alloc_ptr),   0);
        check("rst_full",   int'(full),        0);
        check("rst_empty",  int'(empty),       1);
        check("rst_err",    int'(err),         0);

        // 1: in-order fill, then drain oldest first
        for (int k = 0; k < 4; k++) cycle(1'b1, k, 1'b0, 4'b0, 4'hf, g);
        check("t1_full", int'(full), 1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 0, 1'b1, 4'b0, 4'hf, g);
            check("t1_grant", g, k);
        end

        // 2: re-allocated slot becomes youngest
        do_reset();
        fill();
        cycle(1'b0, 0, 1'b1, 4'b0, 4'b0010, g);
        check("t2_issue1", g, 1);
        cycle(1'b1, 1, 1'b0, 4'b0, 4'b0, g);
        cycle(1'b0, 0, 1'b1, 4'b0, 4'b1110, g); check("t2_g0", g, 2);
        cycle(1'b0, 0, 1'b1, 4'b0, 4'b1110, g); check("t2_g1", g, 3);
        cycle(1'b0, 0, 1'b1, 4'b0, 4'b1110, g); check("t2_g2", g, 1);

        // 3: grant follows req without an issue
        do_reset();
        fill();
        cycle(1'b0, 0, 1'b0, 4'b0, 4'b1010, g); check("t3_g1", g, 1);
        cycle(1'b0, 0, 1'b0, 4'b0, 4'b1000, g); check("t3_g3", g, 3);

        // 4: flush and issue on the same edge
        do_reset();
        fill();
        cycle(1'b0, 0, 1'b1, 4'b0101, 4'b0010, g);
        check("t4_occ", int'(occupied), 4'b1000);
        check("t4_ptr", int'(alloc_ptr), 0);

        // 5: issue oldest while allocating another slot
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, k, 1'b0, 4'b0, 4'b0, g);
        cycle(1'b1, 3, 1'b1, 4'b0, 4'b0001, g);
        check("t5_issue", g, 0);
        check("t5_occ", int'(occupied), 4'b1110);
        for (int k = 1; k < 4; k++) begin
            cycle(1'b0, 0, 1'b1, 4'b0, 4'b1110, g);
            check("t5_grant", g, k);
        end

        // 6: protocol errors are sticky until reset
        do_reset();
        fill();
        cycle(1'b1, 0, 1'b0, 4'b0, 4'b0, g);
        check("t6_err_full", int'(err), 1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 0, 1'b0, 4'b0, 4'b0, g);
        check("t6_err_sticky", int'(err), 1);
        do_reset();
        check("t6_err_clr", int'(err), 0);
        cycle(1'b1, 0, 1'b0, 4'b0, 4'b0, g);
        cycle(1'b1, 2, 1'b0, 4'b0, 4'b0, g);
        check("t6_err_idx", int'(err), 1);
        alloc_valid = 1'b1;
        alloc_idx   = 2'(m_ptr());
        req_vec     = 4'hf;
        do_reset();
        check("t6_rst_occ",   int'(occupied), 0);
        check("t6_rst_empty", int'(empty),    1);
        check("t6_rst_err",   int'(err),      0);

        // Random traffic with occasional protocol violations
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) do_reset();
            rq = 4'($urandom_range(0, 15));
            if (order.size() == 4) av = ($urandom_range(0, 31) == 0);
            else av = ($urandom_range(0, 1) == 1);
            ai = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, 3)) : m_ptr();
            if (m_grant(rq) >= 0) fi = ($urandom_range(0, 2) != 0);
            else fi = ($urandom_range(0, 63) == 0);
            fl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            cycle(av, ai, fi, fl, rq, g);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
